fir_sample_feeder: RTL
======================

Name: fir_sample_feeder

Overview:
- Upstream stage of the 128-tap time-multiplexed FIR filter.
- Accepts bursty 18-bit signed ADC samples into a small FIFO. Presents one sample at a time on `fir_sig`, held stable, while driving the FIR's `ready` enable for exactly TAPS consecutive cycles, one MAC window per sample.
- Flags the cycle in which the FIR's `filtred_sig` carries a new result, so downstream logic can capture it without knowing the FIR's internal counter.

Parameters:
- DATA_W, 18: sample width, signed two's complement.
- TAPS, 128: FIR enable cycles per sample. Must equal the FIR tap count (power of 2).
- DEPTH, 16: FIFO depth in samples. Power of 2, minimum 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- adc_data  in  DATA_W  incoming sample, signed.
- adc_valid  in  1  adc_data valid this cycle.
- adc_ready  out  1  high when the FIFO is not full.
- fir_sig  out  DATA_W  sample to FIR `input_sig`; stable for the whole burst.
- fir_ready  out  1  FIR `ready` enable; high for exactly TAPS consecutive cycles per sample.
- out_strobe  out  1  one-cycle pulse; FIR `filtred_sig` holds a new result this cycle.
- overflow  out  1  sticky; a sample was dropped because the FIFO was full.
- fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst high at a clk edge) sets:
  - FIFO empty, fifo_level=0, adc_ready=1.
  - fir_sig=0, fir_ready=0, out_strobe=0, overflow=0.
  - state IDLE, burst counter cnt=0.
  - Reset overrides every other event in the same cycle.
- FIFO push:
  - A push happens when adc_valid=1 and the registered fifo_level<DEPTH.
  - If adc_valid=1 and the FIFO is full, the sample is dropped and overflow is set to 1. overflow stays high until rst.
  - The full check uses the pre-edge level. A push while full is dropped even if a pop occurs in the same cycle.
  - Simultaneous push and pop on a non-full FIFO leaves fifo_level unchanged.
- Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- FSM states: IDLE, RUN.
  - IDLE: fir_ready=0. If fifo_level>0: pop the head into fir_sig, set cnt=0, go to RUN. Otherwise stay in IDLE.
  - RUN: fir_ready=1 and cnt increments every cycle.
  - When cnt=TAPS-1 (last burst cycle), return to IDLE; see the optional feature for the gapless variant.
  - fir_sig never changes while in RUN.
- out_strobe is asserted in the cycle immediately after the last RUN cycle. That is the first cycle in which the FIR output register reflects the finished window.
- Latency with an empty FIFO, TAPS=128:
  - Sample accepted in cycle 0.
  - Popped in cycle 1 (IDLE).
  - fir_ready high in cycles 2..129.
  - out_strobe in cycle 130.
- Throughput: one sample per TAPS+1 cycles.
- Empty FIFO: the block stays in IDLE with fir_ready low. The FIR holds its position and no spurious strobe is generated.
- Reset mid-burst aborts the burst immediately. The FIR carries no reset, so its phase is then lost. System rule: assert rst only while the block is IDLE, or together with FIR re-initialisation.
- fir_sig is passed through unmodified; no width change or rounding.

Optional Feature:
- Macro: FIR_FEED_GAPLESS_EN.
- Defined: in the last RUN cycle, if fifo_level>0, pop the head into fir_sig, reset cnt=0 and stay in RUN. fir_ready stays high continuously, giving one sample per TAPS cycles. out_strobe timing is unchanged: it pulses in the first cycle of the following burst.
- Undefined: every burst is followed by at least one IDLE cycle with fir_ready low.

Test Plan:
- rst held 3 cycles, then released with no input -> fir_ready=0, out_strobe=0, fifo_level=0, adc_ready=1, overflow=0 for 300 cycles.
- Single sample 18'sd1000 in cycle 0 -> fir_sig=1000 from cycle 2; fir_ready high in cycles 2..129 only; out_strobe only in cycle 130.
- Three back-to-back samples (5, -7, 9) -> fir_sig shows 5, -7, 9 in order, each for 128 ready cycles.
  - Gaps: one idle cycle between bursts; with FIR_FEED_GAPLESS_EN defined, zero gaps.
  - Three out_strobe pulses.
- 20 consecutive valid samples with DEPTH=16 while the first burst runs:
  - adc_ready falls once fifo_level=16.
  - Excess samples are dropped and overflow=1 stays latched.
  - Accepted samples emerge in order.
- Push while full in the same cycle the FSM pops -> pushed sample dropped, overflow=1, fifo_level decreases by 1.
- rst asserted at burst cycle 60 -> next cycle fir_ready=0, FIFO empty, state IDLE, no out_strobe.

Source files
------------

// File: rtl/fir_sample_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : fir_sample_feeder
//  Description : Upstream feeder for a time-multiplexed TAPS-tap FIR filter.
//                Buffers bursty ADC samples in a small FIFO. Holds one sample
//                on fir_sig while fir_ready is high for exactly TAPS
//                consecutive cycles, which is one MAC window. Pulses
//                out_strobe in the cycle the FIR output carries the
//                finished result.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk         in   system clock, rising edge
//    rst         in   synchronous reset, active-high
//    adc_data    in   DATA_W signed sample
//    adc_valid   in   adc_data valid this cycle
//    adc_ready   out  FIFO not full
//    fir_sig     out  sample to FIR input_sig, stable for a whole burst
//    fir_ready   out  FIR ready enable, TAPS consecutive cycles per sample
//    out_strobe  out  one-cycle pulse: FIR filtred_sig holds a new result
//    overflow    out  sticky: a sample was dropped because the FIFO was full
//    fifo_level  out  current FIFO occupancy
//  Configuration
//    FIR_FEED_GAPLESS_EN : when defined, the next sample is popped in the
//                          last cycle of a burst, so fir_ready stays high
//                          continuously while samples are available.
// ============================================================================
module fir_sample_feeder #(
  parameter int DATA_W = 18,
  parameter int TAPS   = 128,
  parameter int DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_W-1:0]          adc_data,
  input  logic                       adc_valid,
  output logic                       adc_ready,
  output logic [DATA_W-1:0]          fir_sig,
  output logic                       fir_ready,
  output logic                       out_strobe,
  output logic                       overflow,
  output logic [$clog2(DEPTH):0]     fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TAPS);
  localparam int LW = AW + 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [LW-1:0]     level;
  logic [0:0]        state;
  logic [CW-1:0]     cnt;

  logic full;
  logic not_empty;
  logic push;
  logic pop;
  logic burst_end;

  always_comb begin
    full      = (level == LW'(DEPTH));
    not_empty = (level != '0);
    // Full check uses the pre-edge level, so a push while full is dropped
    // even if the FSM pops in the same cycle.
    push      = adc_valid & ~full;
    burst_end = (state == ST_RUN) && (cnt == CW'(TAPS - 1));
`ifdef FIR_FEED_GAPLESS_EN
    pop       = not_empty & ((state == ST_IDLE) | burst_end);
`else
    pop       = not_empty & (state == ST_IDLE);
`endif
  end

  // The sample storage has no reset. Only entries below the level are
  // ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= adc_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      fir_sig    <= '0;
      out_strobe <= 1'b0;
      overflow   <= 1'b0;
      state      <= ST_IDLE;
      cnt        <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        fir_sig <= mem[rd_ptr];
      end

      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase

      if (adc_valid && full) begin
        overflow <= 1'b1;
      end

      // The FIR output register reflects the finished window one cycle
      // after the last enable cycle.
      out_strobe <= burst_end;

      if (pop) begin
        state <= ST_RUN;
        cnt   <= '0;
      end else if (state == ST_RUN) begin
        if (burst_end) begin
          state <= ST_IDLE;
        end
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign adc_ready  = ~full;
  assign fir_ready  = (state == ST_RUN);
  assign fifo_level = level;

endmodule
`default_nettype wire
